irl_tb_refill: RTL and testbench



---
 rtl/irl_tb_refill_pkg.sv | 49 ++++
 rtl/irl_tb_refill_tag_fifo.sv | 49 ++++
 rtl/irl_tb_refill.sv | 178 +++++++++++++++++
 tb/tb_irl_tb_refill.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irl_tb_refill_pkg.sv
// rtl/irl_tb_refill_pkg.sv - shared widths, types and refill arithmetic for the token-bucket refill block
package irl_tb_refill_pkg;

  localparam int FLOW_VALUE_DEPTH_NBITS = 4;
  localparam int CIR_NBITS              = 8;
  localparam int EIR_NBITS              = 8;
  localparam int LIMITER_NBITS          = 4;
  localparam int FILL_TB_NBITS          = 8;

  localparam int DEPTH_NBITS    = FLOW_VALUE_DEPTH_NBITS;
  localparam int NUM_FLOWS      = 1 << DEPTH_NBITS;
  localparam int CIR_TB_NBITS   = CIR_NBITS + 2;
  localparam int EIR_TB_NBITS   = EIR_NBITS + 2;
  localparam int BUCKET_NBITS   = CIR_TB_NBITS + EIR_TB_NBITS;
  localparam int LP_FIELD_NBITS = CIR_TB_NBITS;
  localparam int LIMITING_PROFILE_NBITS = 2 * LP_FIELD_NBITS;
  localparam int TAG_DEPTH      = 4;
  localparam int TAG_LVL_NBITS  = $clog2(TAG_DEPTH + 1);

  typedef struct packed {
    logic [LP_FIELD_NBITS-1:0] burst;
    logic [LP_FIELD_NBITS-1:0] rate;
  } lp_fields_t;

  typedef struct packed {
    logic [CIR_TB_NBITS-1:0] cir_tb;
    logic [EIR_TB_NBITS-1:0] eir_tb;
  } tb_bucket_t;

  typedef enum logic [3:0] {
    IDLE, RD_SRC, WT_SRC, RD_PROF, WT_PROF, RD_TB, WT_TB, WR_TB, NEXT
  } refill_state_e;

  localparam logic OWNER_PP     = 1'b0;
  localparam logic OWNER_REFILL = 1'b1;

  // Sum carries one extra bit so an overflowing add still clamps to burst;
  // a bucket already above burst also lands on burst.
  function automatic logic [LP_FIELD_NBITS-1:0] refill_add(
    input logic [LP_FIELD_NBITS-1:0] cur,
    input lp_fields_t                lp
  );
    logic [LP_FIELD_NBITS:0] sum;
    sum = {1'b0, cur} + {1'b0, lp.rate};
    if (sum > {1'b0, lp.burst}) refill_add = lp.burst;
    else                        refill_add = sum[LP_FIELD_NBITS-1:0];
  endfunction

endpackage

// File: rtl/irl_tb_refill_tag_fifo.sv
// rtl/irl_tb_refill_tag_fifo.sv - in-order owner-tag FIFO for outstanding bucket RAM reads
module irl_tb_tag_fifo
  import irl_tb_refill_pkg::*;
#(
  parameter int DEPTH     = TAG_DEPTH,
  parameter int LVL_NBITS = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 push_tag,
  input  logic                 pop,
  output logic                 pop_valid,
  output logic                 pop_tag,
  output logic [LVL_NBITS-1:0] level
);

  localparam int PTR_NBITS = $clog2(DEPTH);

  logic                 tags [DEPTH];
  logic [PTR_NBITS-1:0] wr_ptr;
  logic [PTR_NBITS-1:0] rd_ptr;
  logic                 do_push;

  // A pop against an empty FIFO is an ack nobody owns any more; drop it.
  assign pop_valid = pop && (level != '0);
  assign do_push   = push && ((level != LVL_NBITS'(DEPTH)) || pop_valid);
  assign pop_tag   = tags[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        tags[wr_ptr] <= push_tag;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop_valid) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop_valid})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/irl_tb_refill.sv
// rtl/irl_tb_refill.sv - token-bucket refill sweep sequencer and bucket RAM port arbiter
module irl_tb_refill
  import irl_tb_refill_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              refill_tick,
  input  logic                              cfg_refill_en,
  input  logic                              pp_tb_rd,
  input  logic [DEPTH_NBITS-1:0]            pp_tb_raddr,
  input  logic                              pp_tb_wr,
  input  logic [DEPTH_NBITS-1:0]            pp_tb_waddr,
  input  logic [BUCKET_NBITS-1:0]           pp_tb_wdata,
  output logic                              pp_tb_ack,
  output logic [BUCKET_NBITS-1:0]           pp_tb_rdata,
  output logic                              tb_rd,
  output logic [DEPTH_NBITS-1:0]            tb_raddr,
  output logic                              tb_wr,
  output logic [DEPTH_NBITS-1:0]            tb_waddr,
  output logic [BUCKET_NBITS-1:0]           tb_wdata,
  input  logic                              tb_ack,
  input  logic [BUCKET_NBITS-1:0]           tb_rdata,
  output logic                              fill_tb_src_rd,
  output logic [DEPTH_NBITS-1:0]            fill_tb_src_raddr,
  input  logic                              fill_tb_src_ack,
  input  logic [FILL_TB_NBITS-1:0]          fill_tb_src_rdata,
  output logic                              prof_rd,
  output logic [LIMITER_NBITS-1:0]          prof_raddr,
  input  logic                              prof_ack,
  input  logic [LIMITING_PROFILE_NBITS-1:0] prof_cir_rdata,
  input  logic [LIMITING_PROFILE_NBITS-1:0] prof_eir_rdata,
  output logic                              refill_busy,
  output logic                              refill_overrun
);

  localparam logic [DEPTH_NBITS-1:0]   LAST_IDX     = DEPTH_NBITS'(NUM_FLOWS - 1);
  localparam logic [TAG_LVL_NBITS-1:0] TAG_RD_LIMIT = TAG_LVL_NBITS'(TAG_DEPTH - 1);

  refill_state_e              state;
  logic [DEPTH_NBITS-1:0]     idx;
  lp_fields_t                 cir_lp;
  lp_fields_t                 eir_lp;
  tb_bucket_t                 rd_bkt;
  tb_bucket_t                 wr_bkt;
  logic [TAG_LVL_NBITS-1:0]   drop_cnt;
  logic [TAG_LVL_NBITS-1:0]   tag_level;
  logic                       pop_valid;
  logic                       pop_tag;
  logic                       pp_rd_ok;
  logic                       pp_wr_ok;
  logic                       ref_rd_gnt;
  logic                       ref_wr_gnt;
  logic                       ack_pp;
  logic                       ack_ref;
  logic                       ack_ref_live;
  logic                       hazard;
  logic                       drop_inc;
  logic                       drop_dec;
  logic                       unused_src_bits;

  assign unused_src_bits = ^fill_tb_src_rdata[FILL_TB_NBITS-1:LIMITER_NBITS];
  assign rd_bkt          = tb_rdata;

  // Packet path owns the port whenever it asks; refill only fills idle slots.
  assign pp_rd_ok   = pp_tb_rd && !rst;
  assign pp_wr_ok   = pp_tb_wr && !rst;
  assign ref_rd_gnt = (state == RD_TB) && !rst && !pp_rd_ok && (tag_level < TAG_RD_LIMIT);
  assign ref_wr_gnt = (state == WR_TB) && !rst && !pp_wr_ok;

  assign tb_rd    = pp_rd_ok || ref_rd_gnt;
  assign tb_raddr = pp_rd_ok ? pp_tb_raddr : (ref_rd_gnt ? idx : '0);
  assign tb_wr    = pp_wr_ok || ref_wr_gnt;
  assign tb_waddr = pp_wr_ok ? pp_tb_waddr : (ref_wr_gnt ? idx : '0);
  assign tb_wdata = pp_wr_ok ? pp_tb_wdata : (ref_wr_gnt ? wr_bkt : '0);

  irl_tb_tag_fifo #(.DEPTH(TAG_DEPTH), .LVL_NBITS(TAG_LVL_NBITS)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tb_rd),
    .push_tag  (pp_rd_ok ? OWNER_PP : OWNER_REFILL),
    .pop       (tb_ack),
    .pop_valid (pop_valid),
    .pop_tag   (pop_tag),
    .level     (tag_level)
  );

  assign ack_pp       = pop_valid && (pop_tag == OWNER_PP);
  assign ack_ref      = pop_valid && (pop_tag == OWNER_REFILL);
  assign ack_ref_live = ack_ref && (drop_cnt == '0);

  // A packet-path write to the flow being refilled invalidates what we read;
  // a read still in flight at that moment must have its ack discarded.
  assign hazard   = pp_wr_ok && (pp_tb_waddr == idx) && ((state == WT_TB) || (state == WR_TB));
  assign drop_inc = hazard && (state == WT_TB) && !ack_ref_live;
  assign drop_dec = ack_ref && (drop_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      cir_lp            <= '0;
      eir_lp            <= '0;
      wr_bkt            <= '0;
      drop_cnt          <= '0;
      pp_tb_ack         <= 1'b0;
      pp_tb_rdata       <= '0;
      fill_tb_src_rd    <= 1'b0;
      fill_tb_src_raddr <= '0;
      prof_rd           <= 1'b0;
      prof_raddr        <= '0;
      refill_busy       <= 1'b0;
      refill_overrun    <= 1'b0;
    end else begin
      fill_tb_src_rd <= 1'b0;
      prof_rd        <= 1'b0;
      refill_overrun <= refill_tick && (state != IDLE);
      pp_tb_ack      <= ack_pp;
      if (ack_pp) pp_tb_rdata <= tb_rdata;
      case ({drop_inc, drop_dec})
        2'b10:   drop_cnt <= drop_cnt + 1'b1;
        2'b01:   drop_cnt <= drop_cnt - 1'b1;
        default: drop_cnt <= drop_cnt;
      endcase

      case (state)
        IDLE: if (refill_tick && cfg_refill_en) begin
          idx               <= '0;
          fill_tb_src_raddr <= '0;
          fill_tb_src_rd    <= 1'b1;
          refill_busy       <= 1'b1;
          state             <= RD_SRC;
        end
        RD_SRC: state <= WT_SRC;
        WT_SRC: if (fill_tb_src_ack) begin
          if (fill_tb_src_rdata[LIMITER_NBITS-1:0] == '0) begin
            state <= NEXT;
          end else begin
            prof_raddr <= fill_tb_src_rdata[LIMITER_NBITS-1:0];
            prof_rd    <= 1'b1;
            state      <= RD_PROF;
          end
        end
        RD_PROF: state <= WT_PROF;
        WT_PROF: if (prof_ack) begin
          cir_lp <= prof_cir_rdata;
          eir_lp <= prof_eir_rdata;
          state  <= RD_TB;
        end
        RD_TB: if (ref_rd_gnt) state <= WT_TB;
        WT_TB: begin
          if (hazard) begin
            state <= RD_TB;
          end else if (ack_ref_live) begin
            wr_bkt <= {refill_add(rd_bkt.cir_tb, cir_lp), refill_add(rd_bkt.eir_tb, eir_lp)};
            state  <= WR_TB;
          end
        end
        WR_TB: begin
          if (hazard)          state <= RD_TB;
          else if (ref_wr_gnt) state <= NEXT;
        end
        NEXT: begin
          if ((idx == LAST_IDX) || !cfg_refill_en) begin
            refill_busy <= 1'b0;
            state       <= IDLE;
          end else begin
            idx               <= idx + 1'b1;
            fill_tb_src_raddr <= idx + 1'b1;
            fill_tb_src_rd    <= 1'b1;
            state             <= RD_SRC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irl_tb_refill.sv
// tb/tb_irl_tb_refill.sv - directed self-checking bench for irl_tb_refill
module tb_irl_tb_refill;
  import irl_tb_refill_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              rst = 1'b1;
  logic                              refill_tick = 1'b0;
  logic                              cfg_refill_en = 1'b0;
  logic                              pp_tb_rd = 1'b0;
  logic [DEPTH_NBITS-1:0]            pp_tb_raddr = '0;
  logic                              pp_tb_wr = 1'b0;
  logic [DEPTH_NBITS-1:0]            pp_tb_waddr = '0;
  logic [BUCKET_NBITS-1:0]           pp_tb_wdata = '0;
  logic                              pp_tb_ack;
  logic [BUCKET_NBITS-1:0]           pp_tb_rdata;
  logic                              tb_rd;
  logic [DEPTH_NBITS-1:0]            tb_raddr;
  logic                              tb_wr;
  logic [DEPTH_NBITS-1:0]            tb_waddr;
  logic [BUCKET_NBITS-1:0]           tb_wdata;
  logic                              tb_ack;
  logic [BUCKET_NBITS-1:0]           tb_rdata;
  logic                              fill_tb_src_rd;
  logic [DEPTH_NBITS-1:0]            fill_tb_src_raddr;
  logic                              fill_tb_src_ack = 1'b0;
  logic [FILL_TB_NBITS-1:0]          fill_tb_src_rdata = '0;
  logic                              prof_rd;
  logic [LIMITER_NBITS-1:0]          prof_raddr;
  logic                              prof_ack;
  logic [LIMITING_PROFILE_NBITS-1:0] prof_cir_rdata = '0;
  logic [LIMITING_PROFILE_NBITS-1:0] prof_eir_rdata = '0;
  logic                              refill_busy;
  logic                              refill_overrun;

  irl_tb_refill dut (
    .clk(clk), .rst(rst), .refill_tick(refill_tick), .cfg_refill_en(cfg_refill_en),
    .pp_tb_rd(pp_tb_rd), .pp_tb_raddr(pp_tb_raddr), .pp_tb_wr(pp_tb_wr),
    .pp_tb_waddr(pp_tb_waddr), .pp_tb_wdata(pp_tb_wdata), .pp_tb_ack(pp_tb_ack),
    .pp_tb_rdata(pp_tb_rdata), .tb_rd(tb_rd), .tb_raddr(tb_raddr), .tb_wr(tb_wr),
    .tb_waddr(tb_waddr), .tb_wdata(tb_wdata), .tb_ack(tb_ack), .tb_rdata(tb_rdata),
    .fill_tb_src_rd(fill_tb_src_rd), .fill_tb_src_raddr(fill_tb_src_raddr),
    .fill_tb_src_ack(fill_tb_src_ack), .fill_tb_src_rdata(fill_tb_src_rdata),
    .prof_rd(prof_rd), .prof_raddr(prof_raddr), .prof_ack(prof_ack),
    .prof_cir_rdata(prof_cir_rdata), .prof_eir_rdata(prof_eir_rdata),
    .refill_busy(refill_busy), .refill_overrun(refill_overrun)
  );

  int checks = 0;
  int errors = 0;

  // Memory, fill-source and profile models
  logic [BUCKET_NBITS-1:0]  mem [NUM_FLOWS];
  logic [LIMITER_NBITS-1:0] lim_tbl [NUM_FLOWS];
  lp_fields_t               cir_tbl [1 << LIMITER_NBITS];
  lp_fields_t               eir_tbl [1 << LIMITER_NBITS];
  logic [1:0]               ram_v = '0;
  logic [BUCKET_NBITS-1:0]  ram_d0 = '0, ram_d1 = '0;
  logic [1:0]               prof_v = '0;
  logic [LIMITER_NBITS-1:0] prof_a0 = '0;

  assign tb_ack   = ram_v[1];
  assign tb_rdata = ram_d1;
  assign prof_ack = prof_v[1];

  always @(posedge clk) begin
    if (tb_wr) mem[tb_waddr] <= tb_wdata;
    ram_v    <= {ram_v[0], tb_rd};
    ram_d0   <= mem[tb_raddr];
    ram_d1   <= ram_d0;
    fill_tb_src_ack   <= fill_tb_src_rd;
    fill_tb_src_rdata <= {{(FILL_TB_NBITS-LIMITER_NBITS){1'b0}}, lim_tbl[fill_tb_src_raddr]};
    prof_v   <= {prof_v[0], prof_rd};
    prof_a0  <= prof_raddr;
    prof_cir_rdata <= cir_tbl[prof_a0];
    prof_eir_rdata <= eir_tbl[prof_a0];
  end

  // Activity monitor
  int ref_wr_cnt [NUM_FLOWS] = '{default: 0};
  int src_cnt    [NUM_FLOWS] = '{default: 0};
  int ref_rd_total = 0;
  int ovr_cnt = 0;
  int ack_n = 0;
  logic [BUCKET_NBITS-1:0] ack_log [64];

  always @(posedge clk) begin
    if (tb_wr && !pp_tb_wr) ref_wr_cnt[tb_waddr] <= ref_wr_cnt[tb_waddr] + 1;
    if (tb_rd && !pp_tb_rd) ref_rd_total <= ref_rd_total + 1;
    if (fill_tb_src_rd) src_cnt[fill_tb_src_raddr] <= src_cnt[fill_tb_src_raddr] + 1;
    if (refill_overrun) ovr_cnt <= ovr_cnt + 1;
    if (pp_tb_ack) begin
      ack_log[ack_n[5:0]] <= pp_tb_rdata;
      ack_n <= ack_n + 1;
    end
  end

  int wr_snap [NUM_FLOWS];
  int src_snap [NUM_FLOWS];
  int rd_snap, ack_snap, ovr_snap;

  function automatic logic [BUCKET_NBITS-1:0] mk(input int c, input int e);
    mk = {CIR_TB_NBITS'(c), EIR_TB_NBITS'(e)};
  endfunction

  function automatic int total_delta(input int now [NUM_FLOWS], input int was [NUM_FLOWS]);
    total_delta = 0;
    for (int i = 0; i < NUM_FLOWS; i++) total_delta += now[i] - was[i];
  endfunction

  task automatic snapshot();
    wr_snap  = ref_wr_cnt;
    src_snap = src_cnt;
    rd_snap  = ref_rd_total;
    ack_snap = ack_n;
    ovr_snap = ovr_cnt;
  endtask

  task automatic tick();
    @(negedge clk); refill_tick = 1'b1;
    @(negedge clk); refill_tick = 1'b0;
  endtask

  task automatic pp_write(input int a, input logic [BUCKET_NBITS-1:0] d);
    @(negedge clk);
    pp_tb_wr = 1'b1; pp_tb_waddr = DEPTH_NBITS'(a); pp_tb_wdata = d;
    @(negedge clk);
    pp_tb_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (refill_busy && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (refill_busy !== 1'b0) begin
      errors++; $display("FAIL %s idle_timeout: busy=%0b expected 0", name, refill_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({refill_busy, fill_tb_src_rd, prof_rd, tb_rd, tb_wr, pp_tb_ack, refill_overrun} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0",
        {refill_busy, fill_tb_src_rd, prof_rd, tb_rd, tb_wr, pp_tb_ack, refill_overrun});
    end
    rst = 1'b0;
    snapshot();
    tick();
    repeat (3) @(negedge clk);
    checks++;
    if (refill_busy !== 1'b0 || total_delta(src_cnt, src_snap) !== 0) begin
      errors++; $display("FAIL tick_disabled: busy=%0b src_reads=%0d expected 0/0",
        refill_busy, total_delta(src_cnt, src_snap));
    end
  endtask

  task automatic test_single_flow();
    pp_write(5, mk(95, 20));
    snapshot();
    cfg_refill_en = 1'b1;
    tick();
    checks++;
    if (refill_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy: got %0b expected 1", refill_busy);
    end
    wait_idle("single");
    checks++;
    if (mem[5] !== mk(100, 24)) begin
      errors++; $display("FAIL single_bucket: got %h expected %h", mem[5], mk(100, 24));
    end
    checks++;
    if (total_delta(ref_wr_cnt, wr_snap) !== 1 || ref_wr_cnt[5] - wr_snap[5] !== 1) begin
      errors++; $display("FAIL single_writes: total=%0d at5=%0d expected 1/1",
        total_delta(ref_wr_cnt, wr_snap), ref_wr_cnt[5] - wr_snap[5]);
    end
    checks++;
    if (total_delta(src_cnt, src_snap) !== NUM_FLOWS) begin
      errors++; $display("FAIL single_src_reads: got %0d expected %0d",
        total_delta(src_cnt, src_snap), NUM_FLOWS);
    end
  endtask

  task automatic test_pp_priority();
    int addrs [6] = '{0, 1, 2, 3, 4, 6};
    int n = 0;
    for (int i = 0; i < 6; i++) pp_write(addrs[i], mk(addrs[i] + 1, 2 * addrs[i] + 3));
    snapshot();
    tick();
    while (!prof_rd && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (prof_rd !== 1'b1) begin
      errors++; $display("FAIL prio_prof_wait: prof_rd=%0b expected 1", prof_rd);
    end
    for (int i = 0; i < 6; i++) begin
      pp_tb_rd = 1'b1; pp_tb_raddr = DEPTH_NBITS'(addrs[i]);
      @(negedge clk);
    end
    pp_tb_rd = 1'b0;
    checks++;
    if (ref_rd_total - rd_snap !== 0) begin
      errors++; $display("FAIL prio_withheld: refill reads=%0d expected 0", ref_rd_total - rd_snap);
    end
    wait_idle("prio");
    checks++;
    if (ack_n - ack_snap !== 6 || ref_rd_total - rd_snap !== 1) begin
      errors++; $display("FAIL prio_counts: pp_acks=%0d refill_reads=%0d expected 6/1",
        ack_n - ack_snap, ref_rd_total - rd_snap);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ack_log[6'(ack_snap + i)] !== mk(addrs[i] + 1, 2 * addrs[i] + 3)) begin
        errors++; $display("FAIL prio_ack%0d: got %h expected %h", i,
          ack_log[6'(ack_snap + i)], mk(addrs[i] + 1, 2 * addrs[i] + 3));
      end
    end
    checks++;
    if (mem[5] !== mk(100, 28)) begin
      errors++; $display("FAIL prio_bucket: got %h expected %h", mem[5], mk(100, 28));
    end
  endtask

  task automatic test_hazard();
    int n = 0;
    pp_write(5, mk(95, 20));
    snapshot();
    tick();
    while (!(tb_rd && !pp_tb_rd && tb_raddr == 5) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!(tb_rd && tb_raddr == 5)) begin
      errors++; $display("FAIL hazard_rd_wait: tb_rd=%0b addr=%0d expected 1/5", tb_rd, tb_raddr);
    end
    @(negedge clk);
    pp_tb_wr = 1'b1; pp_tb_waddr = 5; pp_tb_wdata = mk(7, 7);
    @(negedge clk);
    pp_tb_wr = 1'b0;
    wait_idle("hazard");
    checks++;
    if (mem[5] !== mk(17, 11)) begin
      errors++; $display("FAIL hazard_bucket: got %h expected %h", mem[5], mk(17, 11));
    end
    checks++;
    if (ref_wr_cnt[5] - wr_snap[5] !== 1 || ref_rd_total - rd_snap !== 2) begin
      errors++; $display("FAIL hazard_counts: writes=%0d reads=%0d expected 1/2",
        ref_wr_cnt[5] - wr_snap[5], ref_rd_total - rd_snap);
    end
  endtask

  task automatic test_overrun();
    snapshot();
    tick();
    repeat (10) @(negedge clk);
    refill_tick = 1'b1;
    @(negedge clk);
    refill_tick = 1'b0;
    checks++;
    if (refill_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_pulse: got %0b expected 1", refill_overrun);
    end
    @(negedge clk);
    checks++;
    if (refill_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_width: got %0b expected 0", refill_overrun);
    end
    wait_idle("overrun");
    checks++;
    if (ovr_cnt - ovr_snap !== 1 || src_cnt[15] - src_snap[15] !== 1 ||
        total_delta(src_cnt, src_snap) !== NUM_FLOWS) begin
      errors++; $display("FAIL overrun_sweep: pulses=%0d last=%0d total=%0d expected 1/1/%0d",
        ovr_cnt - ovr_snap, src_cnt[15] - src_snap[15], total_delta(src_cnt, src_snap), NUM_FLOWS);
    end
    checks++;
    if (mem[5] !== mk(27, 15)) begin
      errors++; $display("FAIL overrun_bucket: got %h expected %h", mem[5], mk(27, 15));
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    lim_tbl[2] = 3;
    pp_write(2, mk(0, 0));
    pp_write(3, mk(1, 1));
    snapshot();
    tick();
    while (!(fill_tb_src_rd && fill_tb_src_raddr == 2) && n < 200) begin @(negedge clk); n++; end
    cfg_refill_en = 1'b0;
    wait_idle("endrop");
    checks++;
    if (mem[2] !== mk(10, 4)) begin
      errors++; $display("FAIL endrop_bucket2: got %h expected %h", mem[2], mk(10, 4));
    end
    checks++;
    if (src_cnt[3] - src_snap[3] !== 0 || total_delta(src_cnt, src_snap) !== 3 || mem[3] !== mk(1, 1)) begin
      errors++; $display("FAIL endrop_idx3: src3=%0d total=%0d mem3=%h expected 0/3/%h",
        src_cnt[3] - src_snap[3], total_delta(src_cnt, src_snap), mem[3], mk(1, 1));
    end
    lim_tbl[2] = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    cfg_refill_en = 1'b1;
    pp_write(1, mk(3, 3));
    snapshot();
    tick();
    while (!prof_rd && n < 200) begin @(negedge clk); n++; end
    pp_tb_rd = 1'b1; pp_tb_raddr = 1;
    @(negedge clk);
    pp_tb_rd = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({refill_busy, fill_tb_src_rd, prof_rd, tb_rd, tb_wr, pp_tb_ack, refill_overrun} !== 7'b0 ||
        pp_tb_rdata !== '0) begin
      errors++; $display("FAIL midreset_outputs: flags=%b rdata=%h expected 0/0",
        {refill_busy, fill_tb_src_rd, prof_rd, tb_rd, tb_wr, pp_tb_ack, refill_overrun}, pp_tb_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pp_tb_ack || refill_busy || tb_rd || tb_wr || prof_rd) bad++;
    end
    checks++;
    if (bad !== 0 || ack_n - ack_snap !== 0 || ref_wr_cnt[5] - wr_snap[5] !== 0) begin
      errors++; $display("FAIL midreset_late_acks: bad=%0d acks=%0d writes=%0d expected 0/0/0",
        bad, ack_n - ack_snap, ref_wr_cnt[5] - wr_snap[5]);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_FLOWS; i++) lim_tbl[i] = '0;
    for (int i = 0; i < (1 << LIMITER_NBITS); i++) begin
      cir_tbl[i] = '0;
      eir_tbl[i] = '0;
    end
    lim_tbl[5] = 3;
    cir_tbl[3].burst = LP_FIELD_NBITS'(100);
    cir_tbl[3].rate  = LP_FIELD_NBITS'(10);
    eir_tbl[3].burst = LP_FIELD_NBITS'(50);
    eir_tbl[3].rate  = LP_FIELD_NBITS'(4);

    test_reset();
    test_single_flow();
    test_pp_priority();
    test_hazard();
    test_overrun();
    test_enable_drop();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
